// File: rtl/reorder_buffer_mwb_pkg.sv
// Shared reorder-buffer definitions: entry state encoding, entry metadata layout
// and the tag-width helper. The dispatch stage reuses all of these.
package reorder_buffer_mwb_pkg;

  localparam int unsigned AREG_W = 5;
  localparam int unsigned PC_W   = 32;

  typedef enum logic [1:0] {
    ROB_EMPTY = 2'd0,
    ROB_BUSY  = 2'd1,
    ROB_DONE  = 2'd2
  } rob_state_e;

  typedef struct packed {
    logic [AREG_W-1:0] rd;
    logic [PC_W-1:0]   pred_pc;
    logic [PC_W-1:0]   next_pc;
    logic              is_store;
  } rob_meta_t;

  function automatic int unsigned idx_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/reorder_buffer_mwb_wb_match.sv
// Combinational writeback matcher for one tag across all channels.
// When several channels carry the same tag, the lowest channel index wins.
module rob_wb_match
  import reorder_buffer_mwb_pkg::*;
#(
  parameter int unsigned NUM_WB = 2,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned XLEN   = 32
) (
  input  logic [IDX_W-1:0]       tag,
  input  logic [NUM_WB-1:0]      wb_valid,
  input  logic [NUM_WB*IDX_W-1:0] wb_tag,
  input  logic [NUM_WB*XLEN-1:0] wb_val,
  input  logic [NUM_WB*PC_W-1:0] wb_next_pc,
  output logic                   hit,
  output logic [XLEN-1:0]        val,
  output logic [PC_W-1:0]        next_pc
);

  // Scan from the highest channel down so the lowest matching channel lands last.
  always_comb begin
    hit     = 1'b0;
    val     = '0;
    next_pc = '0;
    for (int i = NUM_WB - 1; i >= 0; i--) begin
      if (wb_valid[i] && (wb_tag[i*IDX_W +: IDX_W] == tag)) begin
        hit     = 1'b1;
        val     = wb_val[i*XLEN +: XLEN];
        next_pc = wb_next_pc[i*PC_W +: PC_W];
      end
    end
  end

endmodule

// File: rtl/reorder_buffer_mwb.sv
// In-order retirement buffer with rename table, multi-channel writeback,
// same-cycle operand bypass and next-PC mispredict flush.
module reorder_buffer_mwb
  import reorder_buffer_mwb_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned NUM_WB   = 2,
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_AREG = 32,
  localparam int unsigned IDX_W   = idx_w(DEPTH)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    issue_valid,
  output logic                    issue_ready,
  input  logic [AREG_W-1:0]       issue_rd,
  input  logic [AREG_W-1:0]       issue_rs1,
  input  logic [AREG_W-1:0]       issue_rs2,
  input  logic [PC_W-1:0]         issue_pred_pc,
  input  logic                    issue_is_store,
  output logic [IDX_W-1:0]        issue_tag,
  output logic                    rs1_busy,
  output logic [IDX_W-1:0]        rs1_tag,
  output logic                    rs1_ready,
  output logic [XLEN-1:0]         rs1_val,
  output logic                    rs2_busy,
  output logic [IDX_W-1:0]        rs2_tag,
  output logic                    rs2_ready,
  output logic [XLEN-1:0]         rs2_val,
  input  logic [NUM_WB-1:0]       wb_valid,
  input  logic [NUM_WB*IDX_W-1:0] wb_tag,
  input  logic [NUM_WB*XLEN-1:0]  wb_val,
  input  logic [NUM_WB*PC_W-1:0]  wb_next_pc,
  output logic                    commit_valid,
  input  logic                    commit_ready,
  output logic [AREG_W-1:0]       commit_rd,
  output logic [XLEN-1:0]         commit_val,
  output logic                    commit_is_store,
  output logic                    flush_out,
  output logic [PC_W-1:0]         flush_pc,
  output logic [IDX_W:0]          count
);

  rob_state_e         st     [DEPTH];
  rob_meta_t          meta   [DEPTH];
  logic [XLEN-1:0]    e_val  [DEPTH];
  logic [NUM_AREG-1:0] ren_valid;
  logic [IDX_W-1:0]   ren_tag [NUM_AREG];
  logic [IDX_W-1:0]   head;
  logic [IDX_W-1:0]   tail;

  logic               ent_hit [DEPTH];
  logic [XLEN-1:0]    ent_val [DEPTH];
  logic [PC_W-1:0]    ent_npc [DEPTH];

  logic               retire;
  logic               issue_fire;
  logic [IDX_W-1:0]   rs1_t, rs2_t;
  logic               rs1_hit, rs2_hit;
  logic [XLEN-1:0]    rs1_fwd, rs2_fwd;
  logic [PC_W-1:0]    rs1_fwd_npc, rs2_fwd_npc;
  logic               unused_fwd_npc;

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    rob_wb_match #(.NUM_WB(NUM_WB), .IDX_W(IDX_W), .XLEN(XLEN)) u_match (
      .tag        (IDX_W'(e)),
      .wb_valid   (wb_valid),
      .wb_tag     (wb_tag),
      .wb_val     (wb_val),
      .wb_next_pc (wb_next_pc),
      .hit        (ent_hit[e]),
      .val        (ent_val[e]),
      .next_pc    (ent_npc[e])
    );
  end

  assign rs1_t = ren_tag[issue_rs1];
  assign rs2_t = ren_tag[issue_rs2];

  rob_wb_match #(.NUM_WB(NUM_WB), .IDX_W(IDX_W), .XLEN(XLEN)) u_rs1_match (
    .tag        (rs1_t),
    .wb_valid   (wb_valid),
    .wb_tag     (wb_tag),
    .wb_val     (wb_val),
    .wb_next_pc (wb_next_pc),
    .hit        (rs1_hit),
    .val        (rs1_fwd),
    .next_pc    (rs1_fwd_npc)
  );

  rob_wb_match #(.NUM_WB(NUM_WB), .IDX_W(IDX_W), .XLEN(XLEN)) u_rs2_match (
    .tag        (rs2_t),
    .wb_valid   (wb_valid),
    .wb_tag     (wb_tag),
    .wb_val     (wb_val),
    .wb_next_pc (wb_next_pc),
    .hit        (rs2_hit),
    .val        (rs2_fwd),
    .next_pc    (rs2_fwd_npc)
  );

  assign unused_fwd_npc = ^{rs1_fwd_npc, rs2_fwd_npc};

  // Head-of-buffer view and flow control.
  assign commit_valid    = (st[head] == ROB_DONE);
  assign commit_rd       = meta[head].rd;
  assign commit_val      = e_val[head];
  assign commit_is_store = meta[head].is_store;
  assign flush_pc        = meta[head].next_pc;
  assign retire          = commit_valid && commit_ready;
  assign flush_out       = retire && (meta[head].next_pc != meta[head].pred_pc);
  assign issue_ready     = (count < (IDX_W+1)'(DEPTH)) && !flush_out;
  assign issue_fire      = issue_valid && issue_ready;
  assign issue_tag       = tail;

  // Operand lookup: completed producer first, then same-cycle writeback bypass.
  always_comb begin
    rs1_busy  = ren_valid[issue_rs1];
    rs1_tag   = rs1_busy ? rs1_t : '0;
    rs1_ready = 1'b1;
    rs1_val   = '0;
    if (rs1_busy) begin
      if (st[rs1_t] == ROB_DONE) rs1_val = e_val[rs1_t];
      else if (rs1_hit)          rs1_val = rs1_fwd;
      else                       rs1_ready = 1'b0;
    end
    rs2_busy  = ren_valid[issue_rs2];
    rs2_tag   = rs2_busy ? rs2_t : '0;
    rs2_ready = 1'b1;
    rs2_val   = '0;
    if (rs2_busy) begin
      if (st[rs2_t] == ROB_DONE) rs2_val = e_val[rs2_t];
      else if (rs2_hit)          rs2_val = rs2_fwd;
      else                       rs2_ready = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ren_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        st[i]    <= ROB_EMPTY;
        meta[i]  <= '0;
        e_val[i] <= '0;
      end
      for (int r = 0; r < NUM_AREG; r++) ren_tag[r] <= '0;
    end else if (rdy_in) begin
      if (flush_out) begin
        head      <= '0;
        tail      <= '0;
        count     <= '0;
        ren_valid <= '0;
        for (int i = 0; i < DEPTH; i++) st[i] <= ROB_EMPTY;
      end else begin
        // Writeback only lands on entries still waiting; stale tags fall through.
        for (int i = 0; i < DEPTH; i++) begin
          if ((st[i] == ROB_BUSY) && ent_hit[i]) begin
            st[i]           <= ROB_DONE;
            e_val[i]        <= ent_val[i];
            meta[i].next_pc <= ent_npc[i];
          end
        end
        if (retire) begin
          st[head] <= ROB_EMPTY;
          head     <= head + 1'b1;
          if (ren_valid[commit_rd] && (ren_tag[commit_rd] == head) &&
              !(issue_fire && (issue_rd == commit_rd)))
            ren_valid[commit_rd] <= 1'b0;
        end
        if (issue_fire) begin
          st[tail]    <= ROB_BUSY;
          meta[tail]  <= '{rd: issue_rd, pred_pc: issue_pred_pc, next_pc: '0,
                           is_store: issue_is_store};
          e_val[tail] <= '0;
          tail        <= tail + 1'b1;
          if (issue_rd != '0) begin
            ren_valid[issue_rd] <= 1'b1;
            ren_tag[issue_rd]   <= tail;
          end
        end
        count <= count + (IDX_W+1)'(issue_fire) - (IDX_W+1)'(retire);
      end
    end
  end

endmodule
